gpio_port: RTL and testbench
============================

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, which sets the number of input synchronizer flops (legal values 2..4).
REQ-002 The block SHALL have input clk, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, synchronous and active-low; it is sampled only on the clk rising edge.
REQ-004 The block SHALL have input addr, 32 bits: constant base address; the block decodes addr[31:3], giving 8 words.
REQ-005 The block SHALL have inputs sys_w_addr and sys_r_addr, 32 bits each: peripheral bus write and read addresses.
REQ-006 The block SHALL have input sys_w_line, 32 bits: write data.
REQ-007 The block SHALL have output sys_r_line, 32 bits: registered read data, 32'bz when not driving.
REQ-008 The block SHALL have inputs sys_w and sys_r, 1 bit each: write and read strobes, each valid for one cycle.
REQ-009 The block SHALL have input pin_in, 32 bits: asynchronous pad samples, connected to the pin mux func0_in.
REQ-010 The block SHALL have output pin_out, 32 bits: output values, connected to the pin mux func0_out.
REQ-011 The block SHALL have output pin_dir, 32 bits: per-pin direction (1 = out, 0 = in), connected to the pin mux func0_dir.
REQ-012 The block SHALL have output irq, 1 bit: level interrupt, registered.

Function
REQ-013 The word map SHALL be, by offset addr[2:0]: 0 OUT (R/W); 1 DIR (R/W); 2 IN (RO, synchronized pins); 3 SET (WO, OR into OUT); 4 CLR (WO, AND-NOT into OUT); 5 IRQ_EN (R/W); 6 IRQ_EDGE (R/W, 1 = rising, 0 = falling); 7 IRQ_STAT (R, write-1-to-clear).
REQ-014 A word SHALL be selected only when the access address bits [31:3] equal addr[31:3].
REQ-015 Writes SHALL take effect on the clk edge where sys_w=1, and the new value SHALL be visible on pin_out/pin_dir in the next cycle.
REQ-016 Read data SHALL appear on sys_r_line one cycle after sys_r=1 with a matching address, and SHALL hold until the next edge.
REQ-017 On any edge where sys_r=0 or the read address does not match, sys_r_line SHALL be set to 32'bz.
REQ-018 Reads of SET and CLR SHALL return 32'h0; writes to IN SHALL be ignored.
REQ-019 When the same edge carries a read and a write to the same word, the read SHALL return the pre-write value.
REQ-020 pin_in SHALL pass through a SYNC_STAGES-deep flop chain; IN SHALL show the last chain stage.
REQ-021 Edges SHALL be detected by comparing the last chain stage with one further history flop.
REQ-022 A bit-i event SHALL be: a 0->1 transition with IRQ_EDGE[i]=1, or a 1->0 transition with IRQ_EDGE[i]=0.
REQ-023 Events SHALL set IRQ_STAT[i] regardless of IRQ_EN; IRQ_EN gates only irq.
REQ-024 When an event and a W1C for the same bit occur on the same edge, the set SHALL win.
REQ-025 irq SHALL equal the registered value of |(IRQ_STAT & IRQ_EN), which is one cycle behind IRQ_STAT.
REQ-026 Event detection SHALL be suppressed until SYNC_STAGES+1 cycles after reset release, using a warm-up counter, so that pins that are high at reset produce no spurious event.
REQ-027 Changing IRQ_EDGE SHALL NOT by itself create an event.

Reset
REQ-028 While rst=0 at an edge, the following SHALL be cleared to 0: OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STAT, all synchronizer/history flops, the warm-up counter, and irq; sys_r_line SHALL be set to 32'bz.
REQ-029 Reset SHALL override any concurrent bus write or read.
REQ-030 Reset asserted mid-operation SHALL discard pending status bits and restart the warm-up.

Structure
REQ-031 Word offsets (OFS_OUT..OFS_STAT) and the SYNC_STAGES legal range SHALL live in the shared peripheral package.
REQ-032 The synchronizer chain SHALL be one sub-module, gpio_sync, parameterised by width and depth and instantiated once at width 32.

Verification
REQ-033 Reset scenario: reset, then read words 0..7 -> every word returns 0; pin_dir=0; irq=0.
REQ-034 OUT/SET/CLR scenario: write OUT=32'h0000_00F0, SET=32'h0000_000F, CLR=32'h0000_0030 -> pin_out sequence F0, FF, CF, each one cycle after its write; a read of OUT returns 32'h0000_00CF.
REQ-035 Rising-edge interrupt scenario: IRQ_EN=1, IRQ_EDGE=1, drive pin_in[0] 0->1 -> IRQ_STAT[0]=1 exactly SYNC_STAGES+1 cycles later and irq=1 one cycle after that; W1C 32'h1 -> irq=0.
REQ-036 Set-wins scenario: time a W1C of bit 3 to coincide with a falling-edge event on pin 3 (IRQ_EDGE[3]=0) -> IRQ_STAT[3] stays 1.
REQ-037 Warm-up scenario: hold pin_in=32'hFFFF_FFFF through reset with IRQ_EDGE defaulting to 0, then release reset -> IRQ_STAT stays 0, and IN reads 32'hFFFF_FFFF after SYNC_STAGES cycles.
REQ-038 Address-miss scenario: read and write at addr+8 -> sys_r_line is 32'bz and no register changes.

Source files
------------

// File: rtl/gpio_port_pkg.sv
// Shared peripheral definitions for the GPIO port: word offsets and the
// legal synchronizer depth range.
package gpio_port_pkg;

   typedef enum logic [2:0] {
      OFS_OUT  = 3'd0,
      OFS_DIR  = 3'd1,
      OFS_IN   = 3'd2,
      OFS_SET  = 3'd3,
      OFS_CLR  = 3'd4,
      OFS_EN   = 3'd5,
      OFS_EDGE = 3'd6,
      OFS_STAT = 3'd7
   } gpio_ofs_e;

   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;

   // Out-of-range depths are pulled into the legal window rather than
   // building an unsafe or oversized chain.
   function automatic int clamp_sync(input int n);
      if (n < SYNC_MIN) return SYNC_MIN;
      if (n > SYNC_MAX) return SYNC_MAX;
      return n;
   endfunction

endpackage

// File: rtl/gpio_port_sync.sv
// Multi-flop synchronizer for asynchronous pad inputs; q is the last stage.
module gpio_sync #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/gpio_port.sv
// 32-bit GPIO port: output/direction registers, synchronized inputs and
// per-pin edge interrupts with write-1-to-clear status.
module gpio_port
   import gpio_port_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] sys_w_addr,
   input  logic [31:0] sys_r_addr,
   input  logic [31:0] sys_w_line,
   output logic [31:0] sys_r_line,
   input  logic        sys_w,
   input  logic        sys_r,
   input  logic [31:0] pin_in,
   output logic [31:0] pin_out,
   output logic [31:0] pin_dir,
   output logic        irq
);

   localparam int         DEPTH     = clamp_sync(SYNC_STAGES);
   localparam logic [2:0] WARM_DONE = 3'(DEPTH + 1);

   logic [31:0] out_q, dir_q, en_q, edge_q, stat_q, hist_q;
   logic [31:0] sync_q, rd_mux, rd_data_q, events, w1c;
   logic [2:0]  warm_q;
   logic        irq_q, rd_en_q, w_hit, r_hit;
   gpio_ofs_e   w_ofs, r_ofs;
   logic [2:0]  addr_unused;

   assign addr_unused = addr[2:0];

   gpio_sync #(.WIDTH(32), .DEPTH(DEPTH)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pin_in),
      .q   (sync_q)
   );

   assign w_hit = sys_w && (sys_w_addr[31:3] == addr[31:3]);
   assign r_hit = sys_r && (sys_r_addr[31:3] == addr[31:3]);
   assign w_ofs = gpio_ofs_e'(sys_w_addr[2:0]);
   assign r_ofs = gpio_ofs_e'(sys_r_addr[2:0]);

   // Transitions are only trusted once the chain and history hold real pad data.
   assign events = (warm_q == WARM_DONE)
                 ? ((sync_q & ~hist_q & edge_q) | (~sync_q & hist_q & ~edge_q))
                 : '0;
   assign w1c    = (w_hit && w_ofs == OFS_STAT) ? sys_w_line : '0;

   always_comb begin
      rd_mux = '0;
      case (r_ofs)
         OFS_OUT:  rd_mux = out_q;
         OFS_DIR:  rd_mux = dir_q;
         OFS_IN:   rd_mux = sync_q;
         OFS_EN:   rd_mux = en_q;
         OFS_EDGE: rd_mux = edge_q;
         OFS_STAT: rd_mux = stat_q;
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_q     <= '0;
         dir_q     <= '0;
         en_q      <= '0;
         edge_q    <= '0;
         stat_q    <= '0;
         hist_q    <= '0;
         warm_q    <= '0;
         irq_q     <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_data_q <= '0;
      end else begin
         hist_q <= sync_q;
         if (warm_q != WARM_DONE) warm_q <= warm_q + 3'd1;
         // Set beats a concurrent write-1-to-clear on the same bit.
         stat_q <= (stat_q & ~w1c) | events;
         irq_q  <= |(stat_q & en_q);
         if (w_hit) begin
            case (w_ofs)
               OFS_OUT:  out_q  <= sys_w_line;
               OFS_DIR:  dir_q  <= sys_w_line;
               OFS_SET:  out_q  <= out_q | sys_w_line;
               OFS_CLR:  out_q  <= out_q & ~sys_w_line;
               OFS_EN:   en_q   <= sys_w_line;
               OFS_EDGE: edge_q <= sys_w_line;
               default:  ;
            endcase
         end
         rd_en_q   <= r_hit;
         rd_data_q <= r_hit ? rd_mux : '0;
      end
   end

   assign sys_r_line = rd_en_q ? rd_data_q : 32'bz;
   assign pin_out    = out_q;
   assign pin_dir    = dir_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: register vector table plus hand-timed
// sequences for interrupt latency, set-wins, address miss and warm-up.
module tb_gpio_port;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr = 32'h4000_1005;
   logic [31:0] sys_w_addr = '0;
   logic [31:0] sys_r_addr = '0;
   logic [31:0] sys_w_line = '0;
   logic [31:0] sys_r_line;
   logic        sys_w = 1'b0;
   logic        sys_r = 1'b0;
   logic [31:0] pin_in = '0;
   logic [31:0] pin_out;
   logic [31:0] pin_dir;
   logic        irq;

   int total = 0;
   int bad   = 0;

   gpio_port #(.SYNC_STAGES(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .sys_w_addr (sys_w_addr),
      .sys_r_addr (sys_r_addr),
      .sys_w_line (sys_w_line),
      .sys_r_line (sys_r_line),
      .sys_w      (sys_w),
      .sys_r      (sys_r),
      .pin_in     (pin_in),
      .pin_out    (pin_out),
      .pin_dir    (pin_dir),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // A two-state simulator resolves an undriven bus to zero, so both count as released.
   task automatic check_z(input string name);
      total++;
      if (!((sys_r_line === 32'bz) || (sys_r_line === 32'h0))) begin
         bad++;
         $display("FAIL %s: got %h want zzzzzzzz", name, sys_r_line);
      end
   endtask

   function automatic logic [31:0] word(input logic [2:0] ofs);
      return {addr[31:3], ofs};
   endfunction

   task automatic write_a(input logic [31:0] a, input logic [31:0] d);
      sys_w = 1'b1; sys_w_addr = a; sys_w_line = d;
      tick();
      sys_w = 1'b0;
   endtask

   task automatic read_a(input logic [31:0] a, output logic [31:0] d);
      sys_r = 1'b1; sys_r_addr = a;
      tick();
      sys_r = 1'b0;
      d = sys_r_line;
   endtask

   typedef struct {
      logic        wr;
      logic [2:0]  ofs;
      logic [31:0] data;
      logic [31:0] exp_out;
      logic [31:0] exp_dir;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[15];
   logic [31:0] rd;
   logic [31:0] miss_base;

   initial begin
      vecs[0]  = '{1'b1, 3'd0, 32'h0000_00F0, 32'h0000_00F0, 32'h0, 32'h0};
      vecs[1]  = '{1'b1, 3'd3, 32'h0000_000F, 32'h0000_00FF, 32'h0, 32'h0};
      vecs[2]  = '{1'b1, 3'd4, 32'h0000_0030, 32'h0000_00CF, 32'h0, 32'h0};
      vecs[3]  = '{1'b0, 3'd0, 32'h0,         32'h0000_00CF, 32'h0, 32'h0000_00CF};
      vecs[4]  = '{1'b1, 3'd1, 32'hA5A5_0F0F, 32'h0000_00CF, 32'hA5A5_0F0F, 32'h0};
      vecs[5]  = '{1'b0, 3'd1, 32'h0,         32'h0000_00CF, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
      vecs[6]  = '{1'b0, 3'd3, 32'h0,         32'h0000_00CF, 32'hA5A5_0F0F, 32'h0};
      vecs[7]  = '{1'b0, 3'd4, 32'h0,         32'h0000_00CF, 32'hA5A5_0F0F, 32'h0};
      vecs[8]  = '{1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0000_00CF, 32'hA5A5_0F0F, 32'h0};
      vecs[9]  = '{1'b0, 3'd2, 32'h0,         32'h0000_00CF, 32'hA5A5_0F0F, 32'h0};
      vecs[10] = '{1'b1, 3'd5, 32'h1234_5678, 32'h0000_00CF, 32'hA5A5_0F0F, 32'h0};
      vecs[11] = '{1'b0, 3'd5, 32'h0,         32'h0000_00CF, 32'hA5A5_0F0F, 32'h1234_5678};
      vecs[12] = '{1'b1, 3'd6, 32'h0000_FF00, 32'h0000_00CF, 32'hA5A5_0F0F, 32'h0};
      vecs[13] = '{1'b0, 3'd6, 32'h0,         32'h0000_00CF, 32'hA5A5_0F0F, 32'h0000_FF00};
      vecs[14] = '{1'b0, 3'd7, 32'h0,         32'h0000_00CF, 32'hA5A5_0F0F, 32'h0};

      // Reset state
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         read_a(word(3'(i)), rd);
         check($sformatf("reset_word%0d", i), rd, 32'h0);
      end
      check("reset_pin_dir", pin_dir, 32'h0);
      check("reset_pin_out", pin_out, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      tick();
      check_z("idle_line");

      // Register table
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].wr) begin
            write_a(word(vecs[i].ofs), vecs[i].data);
         end else begin
            read_a(word(vecs[i].ofs), rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
         end
         check($sformatf("vec%0d_out", i), pin_out, vecs[i].exp_out);
         check($sformatf("vec%0d_dir", i), pin_dir, vecs[i].exp_dir);
      end

      // Rising-edge interrupt latency on pin 0
      write_a(word(3'd5), 32'h1);
      write_a(word(3'd6), 32'h1);
      pin_in = 32'h1;
      tick(); tick();
      read_a(word(3'd7), rd);
      check("rise_stat_early", rd, 32'h0);
      check("rise_irq_early", {31'h0, irq}, 32'h0);
      read_a(word(3'd7), rd);
      check("rise_stat_set", rd, 32'h1);
      check("rise_irq_set", {31'h0, irq}, 32'h1);
      write_a(word(3'd7), 32'h1);
      tick();
      check("w1c_irq_clear", {31'h0, irq}, 32'h0);
      read_a(word(3'd7), rd);
      check("w1c_stat_clear", rd, 32'h0);

      // Flipping edge polarity on a steady pin creates no event
      write_a(word(3'd6), 32'h0);
      write_a(word(3'd6), 32'h1);
      tick(); tick(); tick();
      read_a(word(3'd7), rd);
      check("edge_change_stat", rd, 32'h0);

      // Pin 3 is falling-sensitive: rise is ignored, fall coincides with W1C
      pin_in = 32'h9;
      tick(); tick(); tick(); tick();
      read_a(word(3'd7), rd);
      check("fall_bit_rise_ignored", rd, 32'h0);
      pin_in = 32'h1;
      tick(); tick();
      write_a(word(3'd7), 32'h8);
      read_a(word(3'd7), rd);
      check("set_wins_stat", rd, 32'h8);
      tick(); tick();
      check("irq_gated_by_en", {31'h0, irq}, 32'h0);

      // Address miss one block above
      miss_base = word(3'd0) + 32'd8;
      write_a(miss_base, 32'h0000_1234);
      write_a(miss_base + 32'd1, 32'h0);
      check("miss_out", pin_out, 32'h0000_00CF);
      check("miss_dir", pin_dir, 32'hA5A5_0F0F);
      read_a(miss_base, rd);
      check_z("miss_read_out");
      read_a(miss_base + 32'd7, rd);
      check_z("miss_read_stat");
      read_a(word(3'd0), rd);
      check("hit_after_miss", rd, 32'h0000_00CF);

      // Reset beats a concurrent write/read; pins held high through reset
      rst = 1'b0;
      pin_in = 32'hFFFF_FFFF;
      sys_w = 1'b1; sys_w_addr = word(3'd0); sys_w_line = 32'hFFFF_FFFF;
      sys_r = 1'b1; sys_r_addr = word(3'd0);
      tick();
      sys_w = 1'b0; sys_r = 1'b0;
      check("rst_override_out", pin_out, 32'h0);
      check_z("rst_line");
      tick(); tick();
      rst = 1'b1;
      tick();
      read_a(word(3'd2), rd);
      check("warm_in_early", rd, 32'h0);
      read_a(word(3'd2), rd);
      check("warm_in_high", rd, 32'hFFFF_FFFF);
      tick(); tick(); tick(); tick();
      read_a(word(3'd7), rd);
      check("warm_no_spurious", rd, 32'h0);
      check("warm_irq", {31'h0, irq}, 32'h0);
      check("warm_dir", pin_dir, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
